// File: rtl/tile_plotter.sv
// rtl/tile_plotter.sv - rasterises TILE_W x TILE_H filled tiles into a VGA x/y/colour/plot port
// One active tile plus a one-entry pending request; back-to-back tiles with no idle cycle.
module tile_plotter #(
   parameter int         TILE_W       = 4,
   parameter int         TILE_H       = 4,
   parameter int         SCREEN_W     = 160,
   parameter int         SCREEN_H     = 120,
   parameter logic [2:0] ERASE_COLOUR = 3'b000
) (
   input  logic       clock,
   input  logic       reset_n,
   input  logic       req_valid,
   output logic       req_ready,
   input  logic [7:0] req_x,
   input  logic [6:0] req_y,
   input  logic [2:0] req_colour,
   input  logic       req_erase,
   output logic [7:0] out_x,
   output logic [6:0] out_y,
   output logic [2:0] out_colour,
   output logic       plot,
   output logic       busy,
   output logic       done
);

   typedef enum logic {IDLE, DRAW} state_t;

   localparam logic [3:0] CX_LAST = 4'(TILE_W - 1);
   localparam logic [3:0] CY_LAST = 4'(TILE_H - 1);
   localparam logic [8:0] SCR_W9  = 9'(SCREEN_W);
   localparam logic [7:0] SCR_H8  = 8'(SCREEN_H);

   state_t     state, state_next;
   logic [7:0] base_x, n_bx;
   logic [6:0] base_y, n_by;
   logic [2:0] base_c, n_c;
   logic [3:0] cx, n_cx;
   logic [3:0] cy, n_cy;

   logic       pend_full;
   logic [7:0] pend_x;
   logic [6:0] pend_y;
   logic [2:0] pend_c;

   logic       accept;
   logic [2:0] req_c;
   logic       last_px;
   logic       launch_pend;
   logic       pend_load;
   logic       done_next;
   logic       draw_next;
   logic       plot_next;
   logic [8:0] sum_x;
   logic [7:0] sum_y;

   assign req_ready = !pend_full;
   assign accept    = req_valid && req_ready;
   assign req_c     = req_erase ? ERASE_COLOUR : req_colour;
   assign last_px   = (state == DRAW) && (cx == CX_LAST) && (cy == CY_LAST);

   always_comb begin
      state_next  = state;
      n_bx        = base_x;
      n_by        = base_y;
      n_c         = base_c;
      n_cx        = cx;
      n_cy        = cy;
      launch_pend = 1'b0;
      pend_load   = 1'b0;
      done_next   = 1'b0;

      case (state)
         IDLE: begin
            if (accept) begin
               state_next = DRAW;
               n_bx = req_x;
               n_by = req_y;
               n_c  = req_c;
               n_cx = 4'd0;
               n_cy = 4'd0;
            end
         end
         DRAW: begin
            if (last_px) begin
               done_next = 1'b1;
               // The pending entry is older than anything arriving now, so it launches first.
               if (pend_full) begin
                  launch_pend = 1'b1;
                  n_bx = pend_x;
                  n_by = pend_y;
                  n_c  = pend_c;
                  n_cx = 4'd0;
                  n_cy = 4'd0;
               end else if (accept) begin
                  n_bx = req_x;
                  n_by = req_y;
                  n_c  = req_c;
                  n_cx = 4'd0;
                  n_cy = 4'd0;
               end else begin
                  state_next = IDLE;
               end
            end else begin
               if (cx == CX_LAST) begin
                  n_cx = 4'd0;
                  n_cy = cy + 4'd1;
               end else begin
                  n_cx = cx + 4'd1;
               end
               pend_load = accept;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   assign draw_next = (state_next == DRAW);
   assign sum_x     = {1'b0, n_bx} + {5'b0, n_cx};
   assign sum_y     = {1'b0, n_by} + {4'b0, n_cy};
   assign plot_next = draw_next && (sum_x < SCR_W9) && (sum_y < SCR_H8);

   always_ff @(posedge clock) begin
      if (!reset_n) begin
         state      <= IDLE;
         base_x     <= 8'd0;
         base_y     <= 7'd0;
         base_c     <= 3'd0;
         cx         <= 4'd0;
         cy         <= 4'd0;
         pend_full  <= 1'b0;
         pend_x     <= 8'd0;
         pend_y     <= 7'd0;
         pend_c     <= 3'd0;
         out_x      <= 8'd0;
         out_y      <= 7'd0;
         out_colour <= 3'd0;
         plot       <= 1'b0;
         busy       <= 1'b0;
         done       <= 1'b0;
      end else begin
         state  <= state_next;
         base_x <= n_bx;
         base_y <= n_by;
         base_c <= n_c;
         cx     <= n_cx;
         cy     <= n_cy;
         if (pend_load) begin
            pend_full <= 1'b1;
            pend_x    <= req_x;
            pend_y    <= req_y;
            pend_c    <= req_c;
         end else if (launch_pend) begin
            pend_full <= 1'b0;
         end
         // Pixel position/colour hold their last values once the plotter goes idle.
         if (draw_next) begin
            out_x      <= sum_x[7:0];
            out_y      <= sum_y[6:0];
            out_colour <= n_c;
         end
         plot <= plot_next;
         busy <= draw_next;
         done <= done_next;
      end
   end

endmodule
